// File: rtl/irda_fir_flag_det_if.sv
// irda_fir_flag_det_if: chip-stream inputs and flag/framing outputs of the
// FIR flag detector. The master side is the chip sampler plus whoever consumes
// the framing flags; the slave side is the detector itself.
interface irda_fir_flag_det_if;

    localparam int unsigned CNT_W = 4;

    // chip sampler side
    logic             fir_rx8_enable;
    logic             fir_rx_i;
    logic             fir_det_enable;

    // detector side
    logic             pa_lock;
    logic [CNT_W-1:0] pa_count;
    logic             sta_detect;
    logic             sto_detect;
    logic             in_frame;
    logic             frame_abort;

    modport master (
        output fir_rx8_enable,
        output fir_rx_i,
        output fir_det_enable,
        input  pa_lock,
        input  pa_count,
        input  sta_detect,
        input  sto_detect,
        input  in_frame,
        input  frame_abort
    );

    modport slave (
        input  fir_rx8_enable,
        input  fir_rx_i,
        input  fir_det_enable,
        output pa_lock,
        output pa_count,
        output sta_detect,
        output sto_detect,
        output in_frame,
        output frame_abort
    );

endinterface

// File: rtl/irda_fir_flag_det.sv
// irda_fir_flag_det: receive-side FIR preamble / start flag / stop flag
// detector. Locks chip phase on the preamble, qualifies STA on that phase,
// frames the data section and flags STO on symbol boundaries.
// Optional build macro IRDA_FIR_STO_TIMEOUT_EN adds a data-symbol timeout that
// aborts the frame after TIMEOUT_SYMS symbols without STO; without it
// frame_abort is tied low and TIMEOUT_SYMS has no effect.
module irda_fir_flag_det #(
    parameter int unsigned PA_MIN       = 4,
    parameter int unsigned TIMEOUT_SYMS = 8400
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    irda_fir_flag_det_if.slave bus
);

    localparam int unsigned SH_W  = 32;
    localparam int unsigned PH_W  = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SYM_W = 16;

    // Patterns as they sit in the shift register: chip 0 is the MSB.
    localparam logic [15:0]      PA_PAT      = 16'h80A8;      // chips 0,8,10,12
    localparam logic [15:0]      STA_HALF    = 16'h0C0C;      // chips 4,5,12,13
    localparam logic [SH_W-1:0]  STA_PAT     = 32'h0C0C_6060; // chips 4,5,12,13,17,18,25,26
    localparam logic [SH_W-1:0]  STO_PAT     = 32'h0C0C_0606; // chips 4,5,12,13,21,22,29,30
    localparam logic [CNT_W-1:0] PA_LOCK_CNT = CNT_W'(PA_MIN);
    localparam logic [CNT_W-1:0] PA_CNT_MAX  = '1;
    localparam logic [PH_W-1:0]  PH_LAST     = '1;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_PA_SYNC,
        ST_PREAMBLE,
        ST_STA_CHK,
        ST_DATA
    } state_t;

    state_t           state;
    logic [SH_W-1:0]  sh;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] pa_count_q;
    logic             pa_lock_q;
    logic             sta_q;
    logic             sto_q;
    logic             in_frame_q;

    logic [SH_W-1:0]  sh_next;
    logic             pa_hit;
    logic             sta_half_hit;
    logic             sta_hit;
    logic             sto_hit;
    logic             boundary;
    logic             sym_edge;

    // Pattern matches are taken on the register contents after this strobe's shift.
    assign sh_next      = {sh[SH_W-2:0], bus.fir_rx_i};
    assign pa_hit       = (sh_next[15:0] == PA_PAT);
    assign sta_half_hit = (sh_next[15:0] == STA_HALF);
    assign sta_hit      = (sh_next == STA_PAT);
    assign sto_hit      = (sh_next == STO_PAT);
    assign boundary     = (phase == PH_LAST);
    assign sym_edge     = (phase[1:0] == 2'b11);

`ifdef IRDA_FIR_STO_TIMEOUT_EN
    localparam logic [SYM_W-1:0] SYM_LIMIT = SYM_W'(TIMEOUT_SYMS);

    logic [SYM_W-1:0] sym_cnt;
    logic [SYM_W-1:0] sym_inc;
    logic             timeout_hit;
    logic             abort_q;

    // Saturating symbol count as it will be after this symbol boundary.
    assign sym_inc     = (sym_cnt == '1) ? sym_cnt : sym_cnt + SYM_W'(1);
    assign timeout_hit = (sym_inc >= SYM_LIMIT);
`else
    logic unused_timeout;

    // Timeout length is meaningless without the timeout logic.
    assign unused_timeout = ^SYM_W'(TIMEOUT_SYMS);
`endif

    // Detector FSM, shift register, phase and all registered outputs.
    always_ff @(posedge clk) begin
        sta_q <= 1'b0;
        sto_q <= 1'b0;
`ifdef IRDA_FIR_STO_TIMEOUT_EN
        abort_q <= 1'b0;
`endif
        if (wb_rst_i || !bus.fir_det_enable) begin
            state      <= ST_HUNT;
            sh         <= '0;
            phase      <= '0;
            pa_count_q <= '0;
            pa_lock_q  <= 1'b0;
            in_frame_q <= 1'b0;
`ifdef IRDA_FIR_STO_TIMEOUT_EN
            sym_cnt    <= '0;
`endif
        end else if (bus.fir_rx8_enable) begin
            sh    <= sh_next;
            phase <= phase + PH_W'(1);
            case (state)
                ST_HUNT: begin
                    // A PA match defines chip phase: the next boundary is 16 chips on.
                    if (pa_hit) begin
                        pa_count_q <= CNT_W'(1);
                        phase      <= '0;
                        state      <= ST_PA_SYNC;
                    end else begin
                        pa_count_q <= '0;
                    end
                end
                ST_PA_SYNC: begin
                    if (boundary) begin
                        if (pa_hit) begin
                            pa_count_q <= pa_count_q + CNT_W'(1);
                            if ((pa_count_q + CNT_W'(1)) == PA_LOCK_CNT) begin
                                pa_lock_q <= 1'b1;
                                state     <= ST_PREAMBLE;
                            end
                        end else begin
                            pa_count_q <= '0;
                            state      <= ST_HUNT;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    // PA and the first STA half are disjoint, PA is checked first.
                    if (boundary) begin
                        if (pa_hit) begin
                            if (pa_count_q != PA_CNT_MAX) begin
                                pa_count_q <= pa_count_q + CNT_W'(1);
                            end
                        end else if (sta_half_hit) begin
                            state <= ST_STA_CHK;
                        end else begin
                            pa_lock_q  <= 1'b0;
                            pa_count_q <= '0;
                            state      <= ST_HUNT;
                        end
                    end
                end
                ST_STA_CHK: begin
                    if (boundary) begin
                        if (sta_hit) begin
                            sta_q      <= 1'b1;
                            in_frame_q <= 1'b1;
                            pa_lock_q  <= 1'b0;
                            state      <= ST_DATA;
`ifdef IRDA_FIR_STO_TIMEOUT_EN
                            sym_cnt    <= '0;
`endif
                        end else begin
                            pa_lock_q  <= 1'b0;
                            pa_count_q <= '0;
                            state      <= ST_HUNT;
                        end
                    end
                end
                ST_DATA: begin
                    // STO holds an illegal 4PPM chip pair, so data cannot alias it.
                    if (sym_edge) begin
`ifdef IRDA_FIR_STO_TIMEOUT_EN
                        sym_cnt <= sym_inc;
`endif
                        if (sto_hit) begin
                            sto_q      <= 1'b1;
                            in_frame_q <= 1'b0;
                            pa_count_q <= '0;
                            state      <= ST_HUNT;
                        end
`ifdef IRDA_FIR_STO_TIMEOUT_EN
                        else if (timeout_hit) begin
                            abort_q    <= 1'b1;
                            in_frame_q <= 1'b0;
                            pa_count_q <= '0;
                            state      <= ST_HUNT;
                        end
`endif
                    end
                end
                default: begin
                    pa_lock_q  <= 1'b0;
                    pa_count_q <= '0;
                    in_frame_q <= 1'b0;
                    state      <= ST_HUNT;
                end
            endcase
        end
    end

    assign bus.pa_lock    = pa_lock_q;
    assign bus.pa_count   = pa_count_q;
    assign bus.sta_detect = sta_q;
    assign bus.sto_detect = sto_q;
    assign bus.in_frame   = in_frame_q;
`ifdef IRDA_FIR_STO_TIMEOUT_EN
    assign bus.frame_abort = abort_q;
`else
    assign bus.frame_abort = 1'b0;
`endif

endmodule

// File: tb/tb_irda_fir_flag_det.sv
// tb_irda_fir_flag_det: directed scenarios for the FIR flag detector.
// Chip patterns are built from chip-index lists; expected pulse positions are
// given as strobe counts (chip 64 = PA lock, 96 = STA, 160 = STO / timeout).
module tb_irda_fir_flag_det;

    localparam int unsigned TB_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    irda_fir_flag_det_if bus ();

    irda_fir_flag_det #(
        .PA_MIN       (4),
        .TIMEOUT_SYMS (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   chip_cnt = 0;
    int   inframe_chips = 0;
    bit   gap_mode = 1'b0;
    int   sta_cnt, sta_chip, sto_cnt, sto_chip, abort_cnt, abort_chip;
    int   lock_rises, lock_chip;
    logic lock_prev;

    // Pulse and lock-edge monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.sta_detect === 1'b1) begin sta_cnt++; sta_chip = chip_cnt; end
        if (bus.sto_detect === 1'b1) begin sto_cnt++; sto_chip = chip_cnt; end
        if (bus.frame_abort === 1'b1) begin abort_cnt++; abort_chip = chip_cnt; end
        if (bus.pa_lock === 1'b1 && lock_prev !== 1'b1) begin
            lock_rises++;
            lock_chip = chip_cnt;
        end
        lock_prev = bus.pa_lock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // One chip strobe; in gap mode preceded by random idle cycles with junk on fir_rx_i.
    task automatic send_chip(input logic b);
        int idle;
        idle = 0;
        if (gap_mode) begin
            while ($urandom_range(0, 4) != 0 && idle < 16) begin
                @(negedge clk);
                bus.fir_rx8_enable = 1'b0;
                bus.fir_rx_i = 1'($urandom_range(0, 1));
                idle++;
            end
        end
        @(negedge clk);
        if (bus.in_frame === 1'b1) inframe_chips++;
        bus.fir_rx8_enable = 1'b1;
        bus.fir_rx_i = b;
        chip_cnt++;
        @(posedge clk);
        #1;
        bus.fir_rx8_enable = 1'b0;
    endtask

    task automatic send_pa();
        for (int i = 0; i < 16; i++) send_chip(i == 0 || i == 8 || i == 10 || i == 12);
    endtask

    task automatic send_sta(input int flip);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b = (i == 4 || i == 5 || i == 12 || i == 13 || i == 17 || i == 18 || i == 25 || i == 26);
            if (i == flip) b = ~b;
            send_chip(b);
        end
    endtask

    task automatic send_sto();
        for (int i = 0; i < 32; i++)
            send_chip(i == 4 || i == 5 || i == 12 || i == 13 || i == 21 || i == 22 || i == 29 || i == 30);
    endtask

    // Legal 4PPM symbol: a single one at chip position v.
    task automatic send_sym(input int v);
        for (int i = 0; i < 4; i++) send_chip(i == v);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_chip(w[i]);
    endtask

    // Detector disable for one clock, then clear bench counters.
    task automatic det_clear();
        @(negedge clk);
        bus.fir_det_enable = 1'b0;
        bus.fir_rx8_enable = 1'b0;
        @(negedge clk);
        bus.fir_det_enable = 1'b1;
        chip_cnt = 0; inframe_chips = 0; gap_mode = 1'b0;
        sta_cnt = 0; sta_chip = -1; sto_cnt = 0; sto_chip = -1;
        abort_cnt = 0; abort_chip = -1; lock_rises = 0; lock_chip = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fir_det_enable = 1'b1;
        bus.fir_rx8_enable = 1'b0;
        bus.fir_rx_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.pa_lock !== 1'b0) begin errors++; $display("FAIL reset_pa_lock got %b want 0", bus.pa_lock); end
        checks++; if (bus.pa_count !== 4'd0) begin errors++; $display("FAIL reset_pa_count got %0d want 0", bus.pa_count); end
        checks++; if (bus.sta_detect !== 1'b0) begin errors++; $display("FAIL reset_sta got %b want 0", bus.sta_detect); end
        checks++; if (bus.sto_detect !== 1'b0) begin errors++; $display("FAIL reset_sto got %b want 0", bus.sto_detect); end
        checks++; if (bus.in_frame !== 1'b0) begin errors++; $display("FAIL reset_in_frame got %b want 0", bus.in_frame); end
        checks++; if (bus.frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b want 0", bus.frame_abort); end
        rst = 1'b0;
        det_clear();
    endtask

    // 4 PA + STA + 8 symbols + STO, optionally with random strobe gaps.
    task automatic test_frame(input bit gaps, input string tag);
        det_clear();
        gap_mode = gaps;
        repeat (4) send_pa();
        checks++; if (lock_chip !== 64) begin errors++; $display("FAIL %s_lock_chip got %0d want 64", tag, lock_chip); end
        checks++; if (bus.pa_count !== 4'd4) begin errors++; $display("FAIL %s_pa_count got %0d want 4", tag, bus.pa_count); end
        send_sta(-1);
        checks++; if (sta_cnt !== 1 || sta_chip !== 96) begin errors++; $display("FAIL %s_sta got %0d pulses at chip %0d want 1 at 96", tag, sta_cnt, sta_chip); end
        checks++; if (bus.in_frame !== 1'b1) begin errors++; $display("FAIL %s_in_frame_after_sta got %b want 1", tag, bus.in_frame); end
        checks++; if (bus.pa_lock !== 1'b0) begin errors++; $display("FAIL %s_lock_after_sta got %b want 0", tag, bus.pa_lock); end
        send_sym(0); send_sym(1); send_sym(2); send_sym(3);
        send_sym(3); send_sym(2); send_sym(1); send_sym(0);
        checks++; if (sto_cnt !== 0) begin errors++; $display("FAIL %s_sto_early got %0d pulses want 0", tag, sto_cnt); end
        send_sto();
        checks++; if (sto_cnt !== 1 || sto_chip !== 160) begin errors++; $display("FAIL %s_sto got %0d pulses at chip %0d want 1 at 160", tag, sto_cnt, sto_chip); end
        checks++; if (bus.in_frame !== 1'b0) begin errors++; $display("FAIL %s_in_frame_after_sto got %b want 0", tag, bus.in_frame); end
        checks++; if (inframe_chips !== 64) begin errors++; $display("FAIL %s_in_frame_chips got %0d want 64", tag, inframe_chips); end
        checks++; if (abort_cnt !== 0) begin errors++; $display("FAIL %s_abort got %0d pulses want 0", tag, abort_cnt); end
        checks++; if (bus.pa_count !== 4'd0) begin errors++; $display("FAIL %s_pa_count_end got %0d want 0", tag, bus.pa_count); end
        gap_mode = 1'b0;
    endtask

    task automatic test_short_preamble();
        det_clear();
        repeat (3) send_pa();
        checks++; if (bus.pa_count !== 4'd3) begin errors++; $display("FAIL short_pa_count3 got %0d want 3", bus.pa_count); end
        send_word(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        checks++; if (bus.pa_count !== 4'd0) begin errors++; $display("FAIL short_pa_count_end got %0d want 0", bus.pa_count); end
        checks++; if (lock_rises !== 0) begin errors++; $display("FAIL short_lock got %0d rises want 0", lock_rises); end
        checks++; if (sta_cnt !== 0) begin errors++; $display("FAIL short_sta got %0d pulses want 0", sta_cnt); end
    endtask

    task automatic test_bad_sta();
        det_clear();
        repeat (16) send_pa();
        checks++; if (bus.pa_count !== 4'd15) begin errors++; $display("FAIL badsta_pa_count_sat got %0d want 15", bus.pa_count); end
        checks++; if (bus.pa_lock !== 1'b1) begin errors++; $display("FAIL badsta_lock_before got %b want 1", bus.pa_lock); end
        send_sta(26);
        repeat (8) send_chip(1'b0);
        checks++; if (sta_cnt !== 0) begin errors++; $display("FAIL badsta_sta got %0d pulses want 0", sta_cnt); end
        checks++; if (bus.pa_lock !== 1'b0) begin errors++; $display("FAIL badsta_lock_after got %b want 0", bus.pa_lock); end
        checks++; if (bus.pa_count !== 4'd0) begin errors++; $display("FAIL badsta_pa_count_after got %0d want 0", bus.pa_count); end
        checks++; if (bus.in_frame !== 1'b0) begin errors++; $display("FAIL badsta_in_frame got %b want 0", bus.in_frame); end
    endtask

    task automatic test_reset_mid_frame();
        det_clear();
        repeat (4) send_pa();
        send_sta(-1);
        send_sym(2); send_sym(0); send_sym(3);
        checks++; if (bus.in_frame !== 1'b1) begin errors++; $display("FAIL midrst_in_frame_before got %b want 1", bus.in_frame); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.pa_lock, bus.sta_detect, bus.sto_detect, bus.in_frame, bus.frame_abort} !== 5'b0)
            begin errors++; $display("FAIL midrst_flags got %b want 00000", {bus.pa_lock, bus.sta_detect, bus.sto_detect, bus.in_frame, bus.frame_abort}); end
        checks++; if (bus.pa_count !== 4'd0) begin errors++; $display("FAIL midrst_pa_count got %0d want 0", bus.pa_count); end
        @(negedge clk);
        rst = 1'b0;
        send_sym(1); send_sym(2); send_sym(3); send_sym(0); send_sym(1);
        send_sto();
        checks++; if (sto_cnt !== 0) begin errors++; $display("FAIL midrst_sto got %0d pulses want 0", sto_cnt); end
        checks++; if (bus.in_frame !== 1'b0) begin errors++; $display("FAIL midrst_in_frame_after got %b want 0", bus.in_frame); end
    endtask

    task automatic test_timeout();
        det_clear();
        repeat (4) send_pa();
        send_sta(-1);
        repeat (15) send_sym(0);
        checks++; if (bus.in_frame !== 1'b1 || abort_cnt !== 0) begin errors++; $display("FAIL timeout_before got in_frame %b aborts %0d want 1 and 0", bus.in_frame, abort_cnt); end
        send_sym(0);
`ifdef IRDA_FIR_STO_TIMEOUT_EN
        checks++; if (abort_cnt !== 1 || abort_chip !== 160) begin errors++; $display("FAIL timeout_abort got %0d pulses at chip %0d want 1 at 160", abort_cnt, abort_chip); end
        checks++; if (bus.in_frame !== 1'b0) begin errors++; $display("FAIL timeout_in_frame got %b want 0", bus.in_frame); end
`else
        checks++; if (abort_cnt !== 0) begin errors++; $display("FAIL timeout_abort got %0d pulses want 0", abort_cnt); end
        checks++; if (bus.in_frame !== 1'b1) begin errors++; $display("FAIL timeout_in_frame got %b want 1", bus.in_frame); end
`endif
        // Disable with a strobe present still clears everything on the next clock.
        @(negedge clk);
        bus.fir_det_enable = 1'b0;
        bus.fir_rx8_enable = 1'b1;
        bus.fir_rx_i = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.pa_lock, bus.in_frame, bus.pa_count} !== 6'b0) begin errors++; $display("FAIL disable_clear got lock %b in_frame %b count %0d want all 0", bus.pa_lock, bus.in_frame, bus.pa_count); end
        bus.fir_rx8_enable = 1'b0;
        bus.fir_det_enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, "frame");
        test_frame(1'b1, "gapped");
        test_short_preamble();
        test_bad_sta();
        test_reset_mid_frame();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irda_fir_flag_det.md
Name: irda_fir_flag_det

Overview:
- Receive-side counterpart of the FIR transmit flag generator.
- Scans the incoming 4PPM chip stream for the preamble (PA), start flag (STA) and stop flag (STO).
- Locks to chip phase from the preamble and qualifies STA against that phase.
- Frames the data section for the downstream 4PPM decoder and CRC checker. Sits between the FIR chip sampler and the decoder.

Parameters:
- PA_MIN, 4: consecutive PA repetitions required before preamble lock (legal range 2..15).
- TIMEOUT_SYMS, 8400: maximum number of data symbols before a frame is aborted. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- fir_rx8_enable  in  1  chip-rate strobe; one chip is sampled per strobe
- fir_rx_i  in  1  received chip
- fir_det_enable  in  1  detector enable; low forces HUNT and clears internal state
- pa_lock  out  1  preamble locked (level)
- pa_count  out  4  PA repetitions counted, saturates at 15
- sta_detect  out  1  one-clk pulse on valid STA
- sto_detect  out  1  one-clk pulse on valid STO
- in_frame  out  1  high from sta_detect to the end of frame
- frame_abort  out  1  one-clk pulse on timeout (tied 0 without the optional feature)

Behaviour:
- Chip patterns, index 0 received first:
  - PA (16 chips): ones at chips 0, 8, 10, 12.
  - STA (32 chips): ones at 4, 5, 12, 13, 17, 18, 25, 26.
  - STO (32 chips): ones at 4, 5, 12, 13, 21, 22, 29, 30.
- Shift register sh[31:0]: on fir_rx8_enable, sh <= {sh[30:0], fir_rx_i}. After shifting chip index i of an N-chip pattern, it sits at sh[N-1-i].
- phase[3:0]: increments on each strobe and wraps 15->0. It is reset to 0 on the strobe where HUNT first sees a PA match. A "boundary" is a strobe with phase==15.
- All state is updated only on strobe cycles. Outputs are registered, so pulses appear the clk after the qualifying strobe.
- States:
  - HUNT: on every strobe, if sh[15:0] (after the shift) matches PA: pa_count<=1 and go to PA_SYNC. Otherwise pa_count stays 0.
  - PA_SYNC, at each boundary:
    - PA match: pa_count++. If the new count equals PA_MIN, set pa_lock and go to PREAMBLE.
    - Mismatch: go to HUNT and clear pa_count.
  - PREAMBLE, at each boundary:
    - PA match: pa_count++ (saturating at 15).
    - sh[15:0] matches the first half of STA (ones at window chips 4, 5, 12, 13): go to STA_CHK.
    - Anything else: go to HUNT, clear pa_lock and pa_count.
  - STA_CHK, at the next boundary:
    - sh[31:0] equals STA: pulse sta_detect, set in_frame, clear pa_lock, reset the symbol counter, go to DATA.
    - Otherwise: go to HUNT.
  - DATA: on strobes with phase[1:0]==3 (symbol boundary), increment the symbol counter (16 bits, saturating) and compare sh[31:0] to STO.
    - Match: pulse sto_detect, clear in_frame, go to HUNT.
    - STO contains the illegal 4PPM chip pair 4,5, so legal data cannot alias to it.
- Simultaneous events:
  - STO match and timeout on the same strobe: STO wins and frame_abort is not pulsed.
  - In PREAMBLE, PA match takes precedence over STA-half match; the two patterns are disjoint.
- fir_det_enable low: on the next clk, state=HUNT, sh=0, phase=0, counters=0, all outputs low, regardless of fir_rx8_enable.
- Reset (also mid-frame) gives the same result as fir_det_enable low: pa_lock=0, pa_count=0, sta_detect=0, sto_detect=0, in_frame=0, frame_abort=0.
- Strobe gaps of any length are allowed; no timing other than strobe count is used.

Optional Feature:
- IRDA_FIR_STO_TIMEOUT_EN defined: in DATA, when the symbol counter reaches TIMEOUT_SYMS without STO, pulse frame_abort for one clk, clear in_frame and go to HUNT.
- Undefined: no timeout logic; DATA persists until STO, disable or reset; frame_abort is constant 0.

Test Plan:
- 4 PA repetitions then STA then 8 legal 4PPM symbols then STO, PA_MIN=4:
  - pa_lock rises 1 clk after the 64th chip strobe.
  - pa_count=4.
  - sta_detect pulses once after chip 96.
  - in_frame is high for 32 data chips plus 32 STO chips.
  - sto_detect pulses once after chip 160.
- 3 PA repetitions then random chips: pa_lock stays 0, pa_count returns to 0, and sta_detect never asserts.
- 16 PA repetitions, then STA with chip 26 flipped to 0: state returns to HUNT after the STA_CHK boundary, no sta_detect, pa_lock=0.
- Frame in progress, assert wb_rst_i for 1 clk mid-data: all outputs 0 on the next clk; a following STO pattern yields no sto_detect.
- With IRDA_FIR_STO_TIMEOUT_EN and TIMEOUT_SYMS=16: valid STA then 16 data symbols without STO gives a frame_abort pulse on the 16th symbol boundary and in_frame drops. Without the macro, the same stimulus leaves in_frame high.
- Random 1-in-5 strobe spacing for the full frame of scenario 1: identical pulse sequence relative to strobe count.
